// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage access unit between EX/MEM and MEM/WB.
// Drives a single-outstanding req/ack data bus, aligns stores, extends loads
// and stalls the pipeline while an access is pending.
// Ports: clk_i, reset_i (sync, active-high); EX/MEM inputs *_im*;
//   dmem_* bus; MEM/WB outputs *_om*; stall_om, misalign_om, bus_err_om.
// Option: define MEM_ACCESS_TIMEOUT_EN to abandon an access after
//   ACK_TIMEOUT wait cycles without ack (bus_err_om pulses for one cycle).
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] alu_out_im32,
  input  logic [31:0] write_data_im32,
  input  logic [4:0]  dst_reg_addr_im5,
  input  logic        enable_wreg_im,
  input  logic        mem_to_reg_im,
  input  logic        mem_write_im,
  input  logic [1:0]  mem_size_im2,
  input  logic        load_unsigned_im,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o4,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] alu_out_om32,
  output logic [4:0]  dst_reg_addr_om5,
  output logic        mem_to_reg_om,
  output logic [31:0] read_data_om32,
  output logic        enable_wreg_om,
  output logic        stall_om,
  output logic        misalign_om,
  output logic        bus_err_om
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [31:0] lat_alu;
  logic [31:0] lat_wdata;
  logic [4:0]  lat_dst;
  logic        lat_wreg;
  logic        lat_m2r;
  logic        lat_mw;
  logic [1:0]  lat_size;
  logic        lat_uns;

  logic        in_wait;
  logic [31:0] alu;
  logic [31:0] wdata;
  logic [4:0]  dst;
  logic        wreg;
  logic        m2r;
  logic        mw;
  logic [1:0]  size;
  logic        uns;

  logic        misalign;
  logic        req;
  logic        done;
  logic        timeout;
  logic        run;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  assign in_wait = (state == WAIT);
  assign run     = ~reset_i;

  // IDLE works from the live EX/MEM bundle, WAIT from the captured copy
  always_comb begin
    if (in_wait) begin
      alu   = lat_alu;
      wdata = lat_wdata;
      dst   = lat_dst;
      wreg  = lat_wreg;
      m2r   = lat_m2r;
      mw    = lat_mw;
      size  = lat_size;
      uns   = lat_uns;
    end else begin
      alu   = alu_out_im32;
      wdata = write_data_im32;
      dst   = dst_reg_addr_im5;
      wreg  = enable_wreg_im;
      m2r   = mem_to_reg_im;
      mw    = mem_write_im;
      size  = mem_size_im2;
      uns   = load_unsigned_im;
    end
  end

  always_comb begin
    misalign = 1'b0;
    unique case (size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = alu[0];
      default: misalign = |alu[1:0];
    endcase
    misalign = misalign & (m2r | mw);
  end

  assign req  = (m2r | mw) & ~misalign;
  assign done = req & dmem_ack_i;

  always_comb begin
    byte_lane = 8'h00;
    unique case (alu[1:0])
      2'd0: byte_lane = dmem_rdata_i[7:0];
      2'd1: byte_lane = dmem_rdata_i[15:8];
      2'd2: byte_lane = dmem_rdata_i[23:16];
      2'd3: byte_lane = dmem_rdata_i[31:24];
    endcase
    half_lane = alu[1] ? dmem_rdata_i[31:16]
                       : dmem_rdata_i[15:0];
    unique case (size)
      2'd0: load_ext = uns ? {24'h0, byte_lane}
                           : {{24{byte_lane[7]}}, byte_lane};
      2'd1: load_ext = uns ? {16'h0, half_lane}
                           : {{16{half_lane[15]}}, half_lane};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    st_be    = 4'hf;
    st_wdata = wdata;
    unique case (size)
      2'd0: begin
        st_be    = 4'b0001 << alu[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'd1: begin
        st_be    = alu[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata[15:0]}};
      end
      default: begin
        st_be    = 4'hf;
        st_wdata = wdata;
      end
    endcase
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  logic [CW-1:0] wait_cnt;

  assign timeout = in_wait & ~dmem_ack_i &
                   (wait_cnt == CW'(ACK_TIMEOUT - 1));

  // held at zero in IDLE so it starts from zero on entering WAIT
  always_ff @(posedge clk_i) begin
    if (reset_i)
      wait_cnt <= '0;
    else if (!in_wait)
      wait_cnt <= '0;
    else if (!dmem_ack_i)
      wait_cnt <= wait_cnt + CW'(1);
  end
`else
  logic cfg_unused;
  assign timeout    = 1'b0;
  assign cfg_unused = (ACK_TIMEOUT > 0);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      lat_alu   <= '0;
      lat_wdata <= '0;
      lat_dst   <= '0;
      lat_wreg  <= 1'b0;
      lat_m2r   <= 1'b0;
      lat_mw    <= 1'b0;
      lat_size  <= '0;
      lat_uns   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            lat_alu   <= alu_out_im32;
            lat_wdata <= write_data_im32;
            lat_dst   <= dst_reg_addr_im5;
            lat_wreg  <= enable_wreg_im;
            lat_m2r   <= mem_to_reg_im;
            lat_mw    <= mem_write_im;
            lat_size  <= mem_size_im2;
            lat_uns   <= load_unsigned_im;
            if (!dmem_ack_i)
              state <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_ack_i || timeout)
            state <= IDLE;
        end
      endcase
    end
  end

  // every output is forced low in the reset cycle
  assign dmem_req_o   = run & req;
  assign dmem_we_o    = run & req & mw;
  assign dmem_addr_o  = (run & req) ? {alu[31:2], 2'b00}
                                    : 32'h0;
  assign dmem_wdata_o = (run & req & mw) ? st_wdata
                                         : 32'h0;
  assign dmem_be_o4   = !(run & req) ? 4'h0
                      : (mw ? st_be : 4'hf);

  assign alu_out_om32     = run ? alu : 32'h0;
  assign dst_reg_addr_om5 = run ? dst : 5'h0;
  assign mem_to_reg_om    = run & m2r;
  assign read_data_om32   = (run & done & m2r) ? load_ext
                                               : 32'h0;
  assign enable_wreg_om   = run & wreg & ~misalign
                          & ~timeout;
  assign stall_om         = run & req & ~dmem_ack_i
                          & ~timeout;
  assign misalign_om      = run & misalign;
  assign bus_err_om       = run & timeout;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus random checks of mem_access_unit
// against an arithmetic model of bus lanes, extension and stall counts.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] alu_out_im32;
  logic [31:0] write_data_im32;
  logic [4:0]  dst_reg_addr_im5;
  logic        enable_wreg_im;
  logic        mem_to_reg_im;
  logic        mem_write_im;
  logic [1:0]  mem_size_im2;
  logic        load_unsigned_im;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o4;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] alu_out_om32;
  logic [4:0]  dst_reg_addr_om5;
  logic        mem_to_reg_om;
  logic [31:0] read_data_om32;
  logic        enable_wreg_om;
  logic        stall_om;
  logic        misalign_om;
  logic        bus_err_om;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ACK_TIMEOUT(4)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .alu_out_im32     (alu_out_im32),
    .write_data_im32  (write_data_im32),
    .dst_reg_addr_im5 (dst_reg_addr_im5),
    .enable_wreg_im   (enable_wreg_im),
    .mem_to_reg_im    (mem_to_reg_im),
    .mem_write_im     (mem_write_im),
    .mem_size_im2     (mem_size_im2),
    .load_unsigned_im (load_unsigned_im),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_be_o4       (dmem_be_o4),
    .dmem_ack_i       (dmem_ack_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .alu_out_om32     (alu_out_om32),
    .dst_reg_addr_om5 (dst_reg_addr_om5),
    .mem_to_reg_om    (mem_to_reg_om),
    .read_data_om32   (read_data_om32),
    .enable_wreg_om   (enable_wreg_om),
    .stall_om         (stall_om),
    .misalign_om      (misalign_om),
    .bus_err_om       (bus_err_om)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(
      input logic [31:0] addr, input logic [1:0] size,
      input logic uns, input logic [31:0] rd);
    int unsigned v;
    int unsigned nb;
    if (size == 2'd0) begin
      nb = 8;
      v  = (rd >> (8 * (addr % 4))) & 32'hff;
    end else if (size == 2'd1) begin
      nb = 16;
      v  = (rd >> (16 * ((addr / 2) % 2))) & 32'hffff;
    end else begin
      return rd;
    end
    if (!uns && ((v >> (nb - 1)) & 1) == 1)
      v = v - (32'd1 << nb);
    return v;
  endfunction

  function automatic logic [31:0] m_be(
      input int kind, input logic [31:0] addr,
      input logic [1:0] size);
    if (kind == 1 || size >= 2) return 32'hf;
    if (size == 0) return 32'd1 << (addr % 4);
    return 32'd3 << (2 * ((addr / 2) % 2));
  endfunction

  function automatic logic [31:0] m_wdata(
      input logic [31:0] wd, input logic [1:0] size);
    if (size == 0) return (wd & 32'hff) * 32'h01010101;
    if (size == 1) return (wd & 32'hffff) * 32'h00010001;
    return wd;
  endfunction

  function automatic bit m_mis(input logic [31:0] addr,
                               input logic [1:0] size);
    if (size == 1) return (addr % 2) != 0;
    if (size >= 2) return (addr % 4) != 0;
    return 0;
  endfunction

  task automatic scramble();
    alu_out_im32     = $urandom;
    write_data_im32  = $urandom;
    dst_reg_addr_im5 = 5'($urandom);
    enable_wreg_im   = 1'($urandom);
    mem_size_im2     = 2'($urandom);
    load_unsigned_im = 1'($urandom);
    mem_to_reg_im    = 1'($urandom);
    mem_write_im     = ~mem_to_reg_im & 1'($urandom);
  endtask

  task automatic set_idle();
    alu_out_im32     = 32'h0;
    write_data_im32  = 32'h0;
    dst_reg_addr_im5 = 5'h0;
    enable_wreg_im   = 1'b0;
    mem_to_reg_im    = 1'b0;
    mem_write_im     = 1'b0;
    mem_size_im2     = 2'd0;
    load_unsigned_im = 1'b0;
    dmem_ack_i       = 1'b0;
    dmem_rdata_i     = 32'h0;
  endtask

  // kind: 0 = non-memory, 1 = load, 2 = store
  task automatic access(input string tag, input int kind,
      input logic [31:0] addr, input logic [1:0] size,
      input logic uns, input logic [31:0] wd,
      input logic [31:0] rd, input int delay,
      input logic [4:0] dst, input logic wreg);
    bit mis;
    @(negedge clk_i);
    alu_out_im32     = addr;
    write_data_im32  = wd;
    dst_reg_addr_im5 = dst;
    enable_wreg_im   = wreg;
    mem_to_reg_im    = (kind == 1);
    mem_write_im     = (kind == 2);
    mem_size_im2     = size;
    load_unsigned_im = uns;
    dmem_ack_i       = 1'b0;
    dmem_rdata_i     = $urandom;
    mis = (kind != 0) && m_mis(addr, size);
    if (kind == 0 || mis) begin
      #2;
      chk({tag, ":req"}, dmem_req_o, 0);
      chk({tag, ":stall"}, stall_om, 0);
      chk({tag, ":mis"}, misalign_om, mis);
      chk({tag, ":wreg"}, enable_wreg_om, wreg & !mis);
      chk({tag, ":alu"}, alu_out_om32, addr);
      chk({tag, ":rd"}, read_data_om32, 0);
      @(posedge clk_i);
      return;
    end
    for (int c = 0; c <= delay; c++) begin
      if (c > 0) begin
        @(negedge clk_i);
        scramble();
      end
      dmem_ack_i   = (c == delay);
      dmem_rdata_i = (c == delay) ? rd : $urandom;
      #2;
      chk({tag, ":req"}, dmem_req_o, 1);
      chk({tag, ":addr"}, dmem_addr_o, addr & ~32'h3);
      chk({tag, ":we"}, dmem_we_o, kind == 2);
      chk({tag, ":be"}, dmem_be_o4, m_be(kind, addr, size));
      if (kind == 2)
        chk({tag, ":wdata"}, dmem_wdata_o, m_wdata(wd, size));
      chk({tag, ":stall"}, stall_om, c != delay);
      chk({tag, ":alu"}, alu_out_om32, addr);
      chk({tag, ":dst"}, dst_reg_addr_om5, dst);
      chk({tag, ":m2r"}, mem_to_reg_om, kind == 1);
      chk({tag, ":mis"}, misalign_om, 0);
      if (c == delay) begin
        chk({tag, ":wreg"}, enable_wreg_om, wreg);
        if (kind == 1)
          chk({tag, ":rd"}, read_data_om32,
              m_load(addr, size, uns, rd));
      end else begin
        chk({tag, ":rd_early"}, read_data_om32, 0);
      end
      @(posedge clk_i);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":ctl"},
        {dmem_req_o, dmem_we_o, dmem_be_o4, stall_om,
         misalign_om, bus_err_om, enable_wreg_om,
         mem_to_reg_om, dst_reg_addr_om5}, 0);
    chk({tag, ":alu"}, alu_out_om32, 0);
    chk({tag, ":rd"}, read_data_om32, 0);
    chk({tag, ":addr"}, dmem_addr_o, 0);
    chk({tag, ":wdata"}, dmem_wdata_o, 0);
  endtask

  initial begin
    int n_stall;
    bit saw_err;
    int kind;
    logic [31:0] a;
    logic [1:0]  sz;

    // reset with a live load and ack on the inputs
    reset_i = 1'b1;
    set_idle();
    alu_out_im32  = 32'h100;
    mem_to_reg_im = 1'b1;
    mem_size_im2  = 2'd2;
    enable_wreg_im = 1'b1;
    dmem_ack_i    = 1'b1;
    dmem_rdata_i  = 32'h12345678;
    @(negedge clk_i);
    #2 chk_all_zero("reset");
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    set_idle();
    #2;
    chk("post_reset:req", dmem_req_o, 0);
    chk("post_reset:stall", stall_om, 0);
    @(posedge clk_i);

    access("ld_word0", 1, 32'h100, 2'd2, 1'b0, 32'h0,
           32'hDEADBEEF, 0, 5'd3, 1'b1);
    access("ld_sbyte", 1, 32'h103, 2'd0, 1'b0, 32'h0,
           32'h80FF1234, 3, 5'd4, 1'b1);
    access("ld_ubyte", 1, 32'h103, 2'd0, 1'b1, 32'h0,
           32'h80FF1234, 3, 5'd5, 1'b1);
    access("st_half", 2, 32'h22, 2'd1, 1'b0, 32'h0000ABCD,
           32'h0, 0, 5'd0, 1'b0);
    access("st_half_w", 2, 32'h22, 2'd1, 1'b0, 32'h0000ABCD,
           32'h0, 2, 5'd0, 1'b0);
    access("ld_mis", 1, 32'h102, 2'd2, 1'b0, 32'h0,
           32'h0, 0, 5'd6, 1'b1);
    access("ld_shalf", 1, 32'h202, 2'd1, 1'b0, 32'h0,
           32'h8001_7FFF, 1, 5'd7, 1'b1);
    access("st_byte", 2, 32'h301, 2'd0, 1'b0, 32'h1234_56A5,
           32'h0, 0, 5'd0, 1'b0);
    access("alu_op", 0, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0,
           32'h0, 0, 5'd9, 1'b1);

    // unanswered access
    @(negedge clk_i);
    set_idle();
    alu_out_im32   = 32'h40;
    mem_to_reg_im  = 1'b1;
    mem_size_im2   = 2'd2;
    enable_wreg_im = 1'b1;
    dst_reg_addr_im5 = 5'd8;
    n_stall = 0;
    saw_err = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk_i);
      #2;
      if (stall_om) n_stall++;
      if (bus_err_om) begin
        saw_err = 1;
        chk("tmo:req", dmem_req_o, 1);
        chk("tmo:stall", stall_om, 0);
        chk("tmo:wreg", enable_wreg_om, 0);
        @(posedge clk_i);
        break;
      end
      @(posedge clk_i);
    end
`ifdef MEM_ACCESS_TIMEOUT_EN
    chk("tmo:stall_cycles", n_stall, 4);
    chk("tmo:bus_err", saw_err, 1);
    @(negedge clk_i);
    set_idle();
    #2 chk("tmo:idle_req", dmem_req_o, 0);
    @(posedge clk_i);
`else
    chk("hold:stall_cycles", n_stall, 100);
    chk("hold:bus_err", saw_err, 0);
`endif
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    set_idle();
    @(posedge clk_i);

    // reset on the second WAIT cycle
    @(negedge clk_i);
    alu_out_im32   = 32'h200;
    mem_to_reg_im  = 1'b1;
    mem_size_im2   = 2'd2;
    enable_wreg_im = 1'b1;
    dst_reg_addr_im5 = 5'd10;
    @(posedge clk_i);
    @(negedge clk_i);
    #2 chk("rstw:stall1", stall_om, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    #2 chk_all_zero("rstw");
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    set_idle();
    #2;
    chk("rstw:idle_req", dmem_req_o, 0);
    chk("rstw:idle_stall", stall_om, 0);
    @(posedge clk_i);
    access("rstw_ld", 1, 32'h204, 2'd2, 1'b0, 32'h0,
           32'h0BAD_F00D, 0, 5'd11, 1'b1);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) a = a & ~32'h1;
        if (sz >= 2) a = a & ~32'h3;
      end
      access("rand", kind, a, sz, 1'($urandom), $urandom,
             $urandom, $urandom_range(0, 3),
             5'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
